// File: rtl/camo_pkg.sv
// Shared constants and FSM state type for the camouflage key loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package camo_pkg;

   // Number of camouflaged cells; each cell takes two select bits.
   localparam int N_CELLS = 6;
   localparam int KEY_W   = 2 * N_CELLS;
   // Bit counter must be able to hold KEY_W itself without wrapping.
   localparam int CNT_W   = $clog2(KEY_W + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SHIFT  = 3'd1,
      PARITY = 3'd2,
      COMMIT = 3'd3,
      ERR    = 3'd4
   } camo_state_t;

endpackage

// File: rtl/camo_key_shifter.sv
// Serial LSB-first key shifter with bit counter and running even parity.
// Latency: a shifted bit is visible in sreg/par the cycle after shift_en.
// Backpressure: none; the caller gates shift_en, and the counter saturates at KEY_W.
module camo_key_shifter #(
   parameter int KEY_W = camo_pkg::KEY_W,
   parameter int CNT_W = $clog2(KEY_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             shift_bit,
   output logic [KEY_W-1:0] sreg,
   output logic [CNT_W-1:0] cnt,
   output logic             par
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(KEY_W);

   // Shift new bits in at the top so the first accepted bit ends up in sreg[0].
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         sreg <= '0;
         cnt  <= '0;
         par  <= 1'b0;
      end else if (shift_en && (cnt != FULL)) begin
         sreg <= {shift_bit, sreg[KEY_W-1:1]};
         cnt  <= cnt + CNT_W'(1);
         par  <= par ^ shift_bit;
      end
   end

endmodule

// File: rtl/camo_key_loader.sv
// Loads a serial parity-protected key frame into the camouflage cell selects.
// Latency: parity bit presented in cycle n -> new key_out and key_update in cycle n+2.
// Backpressure: key_ready low outside SHIFT/PARITY; key_valid low stalls indefinitely.
module camo_key_loader
   import camo_pkg::*;
#(
   parameter  int N_CELLS = camo_pkg::N_CELLS,
   localparam int KEY_W   = 2 * N_CELLS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic             key_valid,
   input  logic             key_bit,
   input  logic             lock_req,
   output logic             key_ready,
   output logic [KEY_W-1:0] key_out,
   output logic             key_update,
   output logic             key_locked,
   output logic             err_parity,
   output logic             frame_rej
);

   localparam int               CW       = $clog2(KEY_W + 1);
   localparam logic [CW-1:0]    LAST_IDX = CW'(KEY_W - 1);

   camo_state_t      state;
   logic [KEY_W-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             par;
   logic             in_frame;
   logic             restart;
   logic             shift_en;

   // A frame_start while receiving aborts; from IDLE it only starts when unlocked.
   always_comb begin
      in_frame = (state == SHIFT) || (state == PARITY);
      restart  = frame_start && (in_frame || ((state == IDLE) && !key_locked));
      shift_en = (state == SHIFT) && key_valid && !frame_start;
   end

   camo_key_shifter #(
      .KEY_W (KEY_W),
      .CNT_W (CW)
   ) u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (restart),
      .shift_en  (shift_en),
      .shift_bit (key_bit),
      .sreg      (sreg),
      .cnt       (cnt),
      .par       (par)
   );

   // Frame FSM together with all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         key_ready  <= 1'b0;
         key_out    <= '0;
         key_update <= 1'b0;
         key_locked <= 1'b0;
         err_parity <= 1'b0;
         frame_rej  <= 1'b0;
      end else begin
         key_update <= 1'b0;
         frame_rej  <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  if (key_locked) begin
                     frame_rej <= 1'b1;
                  end else begin
                     state      <= SHIFT;
                     key_ready  <= 1'b1;
                     err_parity <= 1'b0;
                  end
               end
            end
            SHIFT: begin
               if (frame_start) begin
                  state <= SHIFT;
               end else if (key_valid && (cnt == LAST_IDX)) begin
                  state <= PARITY;
               end
            end
            PARITY: begin
               if (frame_start) begin
                  state <= SHIFT;
               end else if (key_valid) begin
                  // Even parity: data parity xor parity bit must be zero.
                  state     <= (par ^ key_bit) ? ERR : COMMIT;
                  key_ready <= 1'b0;
               end
            end
            COMMIT: begin
               key_out    <= sreg;
               key_update <= 1'b1;
               if (lock_req) begin
                  key_locked <= 1'b1;
               end
               state <= IDLE;
            end
            ERR: begin
               err_parity <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               state     <= IDLE;
               key_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
